// File: rtl/atm_pin_verifier_if.sv
// Keypad/card-side signal bundle between the PIN verifier and its environment.
// The master side drives the card and keypad inputs; the verifier is the slave.
interface atm_pin_verifier_if #(
    parameter int PIN_DIGITS = 4
);
    localparam int CNT_W = $clog2(PIN_DIGITS + 1);

    logic                    cardIn;
    logic                    digitValid;
    logic [3:0]              digit;
    logic                    clearKey;
    logic                    enterKey;
    logic [4*PIN_DIGITS-1:0] storedPin;
    logic                    correctPassword;
    logic                    pinOk;
    logic                    pinFail;
    logic                    cardRetain;
    logic                    timeoutEject;
    logic [CNT_W-1:0]        digitCount;
    logic [2:0]              triesLeft;

    modport master (
        output cardIn, digitValid, digit, clearKey, enterKey, storedPin,
        input  correctPassword, pinOk, pinFail, cardRetain, timeoutEject,
               digitCount, triesLeft
    );

    modport slave (
        input  cardIn, digitValid, digit, clearKey, enterKey, storedPin,
        output correctPassword, pinOk, pinFail, cardRetain, timeoutEject,
               digitCount, triesLeft
    );
endinterface

// File: rtl/atm_pin_verifier.sv
// PIN collection and authentication ahead of the ATM transaction controller:
// digit buffering, compare against the card PIN, retry limit and inactivity abort.
module atm_pin_verifier #(
    parameter int PIN_DIGITS     = 4,
    parameter int MAX_TRIES      = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    atm_pin_verifier_if.slave     bus
);
    localparam int CNT_W  = $clog2(PIN_DIGITS + 1);
    localparam int BUF_W  = 4 * PIN_DIGITS;
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0]  CNT_FULL   = CNT_W'(PIN_DIGITS);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [2:0]        TRIES_INIT = 3'(MAX_TRIES);
    localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_COLLECT,
        S_CHECK,
        S_GRANTED,
        S_LOCKED
    } state_t;

    state_t            state_q, state_nx;
    logic [BUF_W-1:0]  pin_buf_q, pin_buf_nx;
    logic [CNT_W-1:0]  cnt_q, cnt_nx;
    logic [2:0]        tries_q, tries_nx;
    logic [IDLE_W-1:0] idle_q, idle_nx;
    logic              ok_q, ok_nx;
    logic              fail_q, fail_nx;
    logic              tout_q, tout_nx;

    always_comb begin
        state_nx   = state_q;
        pin_buf_nx = pin_buf_q;
        cnt_nx     = cnt_q;
        tries_nx   = tries_q;
        idle_nx    = idle_q;
        ok_nx      = 1'b0;
        fail_nx    = 1'b0;
        tout_nx    = 1'b0;

        // Leaving for IDLE restores the idle values on the same edge, so a
        // pulled card never leaves a stale digit count or retry count behind.
        if (state_q == S_IDLE ||
            (!bus.cardIn && state_q inside {S_COLLECT, S_CHECK, S_GRANTED})) begin
            state_nx   = (state_q == S_IDLE && bus.cardIn) ? S_COLLECT : S_IDLE;
            pin_buf_nx = '0;
            cnt_nx     = '0;
            tries_nx   = TRIES_INIT;
            idle_nx    = '0;
        end else begin
            case (state_q)
                S_COLLECT: begin
                    if (bus.clearKey) begin
                        pin_buf_nx = '0;
                        cnt_nx     = '0;
                        idle_nx    = '0;
                    end else if (bus.enterKey && cnt_q == CNT_FULL) begin
                        state_nx = S_CHECK;
                        idle_nx  = '0;
                    end else if (bus.digitValid && bus.digit <= 4'd9 && cnt_q < CNT_FULL) begin
                        pin_buf_nx = (pin_buf_q << 4) | {{(BUF_W-4){1'b0}}, bus.digit};
                        cnt_nx     = cnt_q + CNT_ONE;
                        idle_nx    = '0;
                    end else if (idle_q == IDLE_LAST) begin
                        tout_nx    = 1'b1;
                        state_nx   = S_IDLE;
                        pin_buf_nx = '0;
                        cnt_nx     = '0;
                        tries_nx   = TRIES_INIT;
                        idle_nx    = '0;
                    end else begin
                        idle_nx = idle_q + IDLE_ONE;
                    end
                end
                S_CHECK: begin
                    if (pin_buf_q == bus.storedPin) begin
                        state_nx = S_GRANTED;
                        ok_nx    = 1'b1;
                    end else if (tries_q > 3'd1) begin
                        state_nx   = S_COLLECT;
                        tries_nx   = tries_q - 3'd1;
                        pin_buf_nx = '0;
                        cnt_nx     = '0;
                        idle_nx    = '0;
                        fail_nx    = 1'b1;
                    end else begin
                        state_nx = S_LOCKED;
                        tries_nx = 3'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tries_q <= TRIES_INIT;
            idle_q  <= '0;
            ok_q    <= 1'b0;
            fail_q  <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
            tries_q <= tries_nx;
            idle_q  <= idle_nx;
            ok_q    <= ok_nx;
            fail_q  <= fail_nx;
            tout_q  <= tout_nx;
        end
    end

    // The digit buffer is pure data: IDLE zeroes it before any COLLECT can use it.
    always_ff @(posedge clk) begin
        pin_buf_q <= pin_buf_nx;
    end

    assign bus.correctPassword = (state_q == S_GRANTED);
    assign bus.cardRetain      = (state_q == S_LOCKED);
    assign bus.pinOk           = ok_q;
    assign bus.pinFail         = fail_q;
    assign bus.timeoutEject    = tout_q;
    assign bus.digitCount      = cnt_q;
    assign bus.triesLeft       = tries_q;
endmodule
